// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int LEN_W  = 4;   // burst length encoded as beats-1

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic              wvalid;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef struct packed {
      logic              ready;
      logic              last;
      logic [DATA_W-1:0] rdata;
   } resp_t;

   // A completed beat is inconsistent with the requested length when the final
   // beat arrives early/late, or a non-final beat arrives once the count is used up.
   function automatic logic burst_len_error(input logic             last,
                                            input logic [LEN_W-1:0] cnt,
                                            input logic [LEN_W-1:0] len);
      return last ? (cnt != len) : (cnt == len);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One request/response bus channel. The side issuing requests uses the master
// modport; the side answering them uses the slave modport.
interface mem_bus_arbiter_if;
   import mem_arb_pkg::*;

   req_t  req;
   resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin select: a lone valid wins outright, a tie goes to the
// side named by prio_d (1 = dbus preferred, 0 = ibus preferred).
module rr_pick2 (
   input  logic valid_i,
   input  logic valid_d,
   input  logic prio_d,
   output logic sel_i,
   output logic sel_d
);

   // Combinational pick; at most one select is ever high.
   always_comb begin
      sel_i = 1'b0;
      sel_d = 1'b0;
      if (valid_i && valid_d) begin
         if (prio_d) sel_d = 1'b1;
         else        sel_i = 1'b1;
      end else if (valid_i) begin
         sel_i = 1'b1;
      end else if (valid_d) begin
         sel_d = 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between the ibus and dbus requesters.
// Whole bursts are granted round-robin; the grant is registered and held until
// the downstream reports the last beat. Data paths are muxes on the registered
// grant, so beats pass through with no added latency.
module mem_bus_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   mem_bus_arbiter_if.slave  ibus,
   mem_bus_arbiter_if.slave  dbus,
   mem_bus_arbiter_if.master mbus,
   output logic              err
);

   arb_state_e       state_q, state_d;
   logic             prio_d_q, prio_d_d;     // 1: dbus wins the next tie
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             err_q, err_d;
   logic             sel_i, sel_d;
   req_t             gnt_req;

   rr_pick2 u_pick (
      .valid_i (ibus.req.valid),
      .valid_d (dbus.req.valid),
      .prio_d  (prio_d_q),
      .sel_i   (sel_i),
      .sel_d   (sel_d)
   );

   // State register; reset returns grant, priority, count and error to idle values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         prio_d_q   <= 1'b0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_d_q   <= prio_d_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   // Next-state: grant from IDLE, count beats, release and rotate priority on the last beat.
   always_comb begin
      state_d    = state_q;
      prio_d_d   = prio_d_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (sel_i)      state_d = GRANT_I;
            else if (sel_d) state_d = GRANT_D;
         end
         GRANT_I, GRANT_D: begin
            if (mbus.resp.ready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (burst_len_error(mbus.resp.last, beat_cnt_q, gnt_req.len))
                  err_d = 1'b1;
               if (mbus.resp.last) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
                  prio_d_d   = (state_q == GRANT_I);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus muxes on the registered grant; the ungranted side sees an all-zero response.
   always_comb begin
      gnt_req   = '0;
      ibus.resp = '0;
      dbus.resp = '0;
      case (state_q)
         GRANT_I: begin
            gnt_req        = ibus.req;
            gnt_req.valid  = 1'b1;     // held even if the requester drops valid mid-burst
            gnt_req.wvalid = 1'b0;     // instruction fetch never writes
            gnt_req.wdata  = '0;
            ibus.resp      = mbus.resp;
         end
         GRANT_D: begin
            gnt_req        = dbus.req;
            gnt_req.valid  = 1'b1;
            dbus.resp      = mbus.resp;
         end
         default: ;
      endcase
   end

   assign mbus.req = gnt_req;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the stimulus thread plays both requesters
// and the downstream memory, pushing each expected beat into a scoreboard; a
// monitor pops and compares whenever a requester sees a ready.
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic err;

   mem_bus_arbiter_if ibus_if ();
   mem_bus_arbiter_if dbus_if ();
   mem_bus_arbiter_if mbus_if ();

   mem_bus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .ibus  (ibus_if),
      .dbus  (dbus_if),
      .mbus  (mbus_if),
      .err   (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        side_d;
      logic        last;
      logic [63:0] rdata;
      logic [63:0] addr;
      logic [3:0]  len;
      logic        wv;
      logic [63:0] wd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One downstream beat this cycle; the expected requester-side view is queued.
   task automatic do_beat(input logic lst, input logic [63:0] rd, input logic side_d,
                          input logic [63:0] addr, input logic [3:0] len,
                          input logic wv, input logic [63:0] wd);
      exp_t e;
      e.side_d = side_d; e.last = lst; e.rdata = rd;
      e.addr = addr; e.len = len; e.wv = wv; e.wd = wd;
      sb.push_back(e);
      mbus_if.resp.ready = 1'b1;
      mbus_if.resp.last  = lst;
      mbus_if.resp.rdata = rd;
      tick();
      mbus_if.resp = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every requester-side ready must match the oldest expected beat.
   initial begin
      exp_t e;
      logic [199:0] act_v, exp_v;
      forever begin
         @(negedge clk);
         if (ibus_if.resp.ready || dbus_if.resp.ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got i_ready=%0b d_ready=%0b expected none",
                        ibus_if.resp.ready, dbus_if.resp.ready);
            end else begin
               e = sb.pop_front();
               act_v = {ibus_if.resp.ready, dbus_if.resp.ready,
                        (dbus_if.resp.ready ? dbus_if.resp.last  : ibus_if.resp.last),
                        (dbus_if.resp.ready ? dbus_if.resp.rdata : ibus_if.resp.rdata),
                        mbus_if.req.valid, mbus_if.req.addr, mbus_if.req.len,
                        mbus_if.req.wvalid, mbus_if.req.wdata};
               exp_v = {~e.side_d, e.side_d, e.last, e.rdata, 1'b1, e.addr, e.len, e.wv, e.wd};
               chk("beat", act_v, exp_v);
               $display("beat side=%s last=%0b rdata=%h addr=%h wdata=%h",
                        e.side_d ? "d" : "i", e.last, e.rdata, e.addr, e.wd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      ibus_if.req  = '0;
      dbus_if.req  = '0;
      mbus_if.resp = '0;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_mreq",  200'(mbus_if.req),  200'd0);
      chk("rst_iresp", 200'(ibus_if.resp), 200'd0);
      chk("rst_dresp", 200'(dbus_if.resp), 200'd0);
      chk("rst_err",   200'(err),          200'd0);
      tick();

      // 1: single ibus beat, m_valid one cycle after i_valid, beat at cycle 3
      reset = 1'b0;
      ibus_if.req = '{valid: 1'b1, addr: 64'h8000_0000, len: 4'd0, wvalid: 1'b0, wdata: 64'd0};
      @(negedge clk); chk("t1_mvalid_c0", 200'(mbus_if.req.valid), 200'd0);
      tick();
      @(negedge clk); chk("t1_mvalid_c1", 200'(mbus_if.req.valid), 200'd1);
                      chk("t1_maddr_c1",  200'(mbus_if.req.addr),  200'h8000_0000);
      tick();
      @(negedge clk); chk("t1_iready_c2", 200'(ibus_if.resp.ready), 200'd0);
      tick();
      do_beat(1'b1, 64'hCAFE_0001, 1'b0, 64'h8000_0000, 4'd0, 1'b0, 64'd0);
      ibus_if.req.valid = 1'b0;
      @(negedge clk); chk("t1_bubble", 200'(mbus_if.req.valid), 200'd0);
      tick();

      // 2: simultaneous requests after reset -> ibus first, then dbus, then ibus again
      do_reset();
      ibus_if.req = '{valid: 1'b1, addr: 64'h1000, len: 4'd1, wvalid: 1'b0, wdata: 64'd0};
      dbus_if.req = '{valid: 1'b1, addr: 64'h2000, len: 4'd1, wvalid: 1'b0, wdata: 64'd0};
      tick();
      do_beat(1'b0, 64'hA1, 1'b0, 64'h1000, 4'd1, 1'b0, 64'd0);
      do_beat(1'b1, 64'hA2, 1'b0, 64'h1000, 4'd1, 1'b0, 64'd0);
      ibus_if.req.valid = 1'b0;
      @(negedge clk); chk("t2_bubble", 200'(mbus_if.req.valid), 200'd0);
      tick();
      @(negedge clk); chk("t2_dgrant", 200'(mbus_if.req.addr), 200'h2000);
      tick();
      do_beat(1'b0, 64'hB1, 1'b1, 64'h2000, 4'd1, 1'b0, 64'd0);
      do_beat(1'b1, 64'hB2, 1'b1, 64'h2000, 4'd1, 1'b0, 64'd0);
      dbus_if.req.valid = 1'b0;
      ibus_if.req = '{valid: 1'b1, addr: 64'h3000, len: 4'd0, wvalid: 1'b0, wdata: 64'd0};
      dbus_if.req = '{valid: 1'b1, addr: 64'h4000, len: 4'd0, wvalid: 1'b0, wdata: 64'd0};
      tick();
      @(negedge clk); chk("t2_rr_back_to_i", 200'(mbus_if.req.addr), 200'h3000);
      tick();
      do_beat(1'b1, 64'hC1, 1'b0, 64'h3000, 4'd0, 1'b0, 64'd0);
      ibus_if.req.valid = 1'b0;
      tick();
      do_beat(1'b1, 64'hC2, 1'b1, 64'h4000, 4'd0, 1'b0, 64'd0);
      dbus_if.req.valid = 1'b0;

      // 3: dbus write burst of 4 beats; ibus arriving mid-burst must wait
      dbus_if.req = '{valid: 1'b1, addr: 64'h5000, len: 4'd3, wvalid: 1'b1, wdata: 64'h11};
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k == 1)
            ibus_if.req = '{valid: 1'b1, addr: 64'h6000, len: 4'd0, wvalid: 1'b0, wdata: 64'd0};
         do_beat(k == 3, 64'hD0 + 64'(k), 1'b1, 64'h5000, 4'd3, 1'b1, 64'h11 * 64'(k + 1));
         dbus_if.req.wdata = 64'h11 * 64'(k + 2);
      end
      dbus_if.req.valid = 1'b0;
      @(negedge clk); chk("t3_bubble", 200'(mbus_if.req.valid), 200'd0);
      tick();
      @(negedge clk); chk("t3_igrant_wvalid", 200'({mbus_if.req.addr, mbus_if.req.wvalid}),
                          200'({64'h6000, 1'b0}));
      tick();
      do_beat(1'b1, 64'hE1, 1'b0, 64'h6000, 4'd0, 1'b0, 64'd0);
      ibus_if.req.valid = 1'b0;

      // 4: early m_last on a 3-beat ibus burst -> sticky err, grant released
      @(negedge clk); chk("t4_err_before", 200'(err), 200'd0);
      tick();
      ibus_if.req = '{valid: 1'b1, addr: 64'h7000, len: 4'd2, wvalid: 1'b0, wdata: 64'd0};
      tick();
      do_beat(1'b0, 64'hF1, 1'b0, 64'h7000, 4'd2, 1'b0, 64'd0);
      do_beat(1'b1, 64'hF2, 1'b0, 64'h7000, 4'd2, 1'b0, 64'd0);
      ibus_if.req.valid = 1'b0;
      @(negedge clk); chk("t4_err_set",  200'(err), 200'd1);
                      chk("t4_released", 200'(mbus_if.req.valid), 200'd0);
      tick();
      dbus_if.req = '{valid: 1'b1, addr: 64'h8000, len: 4'd0, wvalid: 1'b0, wdata: 64'd0};
      tick();
      do_beat(1'b1, 64'hF3, 1'b1, 64'h8000, 4'd0, 1'b0, 64'd0);
      dbus_if.req.valid = 1'b0;
      @(negedge clk); chk("t4_err_sticky", 200'(err), 200'd1);
      tick();

      // 5: reset during 2nd beat of a 4-beat dbus burst; pending request regranted fresh
      dbus_if.req = '{valid: 1'b1, addr: 64'h9000, len: 4'd3, wvalid: 1'b0, wdata: 64'd0};
      tick();
      do_beat(1'b0, 64'h91, 1'b1, 64'h9000, 4'd3, 1'b0, 64'd0);
      reset = 1'b1;
      do_beat(1'b0, 64'h92, 1'b1, 64'h9000, 4'd3, 1'b0, 64'd0);
      reset = 1'b0;
      @(negedge clk); chk("t5_mreq_zero",  200'(mbus_if.req),  200'd0);
                      chk("t5_dresp_zero", 200'(dbus_if.resp), 200'd0);
                      chk("t5_err_clear",  200'(err),          200'd0);
      tick();
      @(negedge clk); chk("t5_regrant", 200'({mbus_if.req.valid, mbus_if.req.addr}),
                          200'({1'b1, 64'h9000}));
      tick();
      for (int k = 0; k < 4; k++)
         do_beat(k == 3, 64'h9A + 64'(k), 1'b1, 64'h9000, 4'd3, 1'b0, 64'd0);
      dbus_if.req.valid = 1'b0;
      @(negedge clk); chk("t5_clean_err", 200'(err), 200'd0);
      tick();

      // 6: ibus drops valid mid-burst; grant held until m_last
      ibus_if.req = '{valid: 1'b1, addr: 64'hA000, len: 4'd2, wvalid: 1'b0, wdata: 64'd0};
      tick();
      do_beat(1'b0, 64'hA61, 1'b0, 64'hA000, 4'd2, 1'b0, 64'd0);
      ibus_if.req.valid = 1'b0;
      @(negedge clk); chk("t6_held", 200'(mbus_if.req.valid), 200'd1);
      tick();
      do_beat(1'b0, 64'hA62, 1'b0, 64'hA000, 4'd2, 1'b0, 64'd0);
      do_beat(1'b1, 64'hA63, 1'b0, 64'hA000, 4'd2, 1'b0, 64'd0);
      @(negedge clk); chk("t6_idle", 200'({mbus_if.req.valid, err}), 200'd0);
      tick();

      // 7: overrun -- non-final beat once the count reaches len sets err
      dbus_if.req = '{valid: 1'b1, addr: 64'hB000, len: 4'd0, wvalid: 1'b0, wdata: 64'd0};
      tick();
      do_beat(1'b0, 64'hB71, 1'b1, 64'hB000, 4'd0, 1'b0, 64'd0);
      @(negedge clk); chk("t7_overrun_err", 200'(err), 200'd1);
      tick();
      do_beat(1'b1, 64'hB72, 1'b1, 64'hB000, 4'd0, 1'b0, 64'd0);
      dbus_if.req.valid = 1'b0;
      tick();
      tick();

      chk("sb_drained", 200'(sb.size()), 200'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
